calc_menu_cu_p: RTL and testbench
=================================

Name: calc_menu_cu_p

Overview:
Parametrised calculator control unit, the next generation of the 8-bit button-driven calculator controller. It handles button-driven operation-menu navigation, operand capture from the switch bus, one-hot operation dispatch, and a start/done handshake with the arithmetic datapath. It adds a width parameter, an operation-count parameter, per-operation unary/binary mode, cancel/back navigation, and a watchdog timeout with an error state. It sits between the debounced board buttons/switches and the arithmetic units.

Parameters:
WIDTH, 8, operand and data bus width in bits
NUM_OPS, 7, number of operations; op index 0..NUM_OPS-1
UNARY_MASK, 7'b1100000, bit i = 1 means op i takes one operand (default: ops 5 and 6, isprime and sqrt, are unary)
TIMEOUT, 255, maximum WAIT cycles allowed before the error state

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset (Reset=0 resets on the next Clk rise)
dataInBus  in  WIDTH  operand value from switches
btl, btr, btu, btd, btc  in  1  debounced level buttons: left, right, up, down, centre
exec_done  in  1  datapath completion, level, sampled only in WAIT
exec_err  in  1  datapath error qualifier, valid with exec_done (e.g. divide by zero)
op_sel  out  NUM_OPS  one-hot currently highlighted operation
op_start  out  NUM_OPS  one-hot single-cycle start pulse for the datapath
num1_out, num2_out  out  WIDTH  latched operands
done  out  1  result valid (SHOW state)
err  out  1  error indication (ERROR state)
busy  out  1  high in EXEC and WAIT
state_out  out  3  state encoding, for display/debug

Behaviour:
- All outputs are registered.
- Reset values: state MENU, op index 0 (op_sel=1), op_start=0, num1_out=0, num2_out=0, done=0, err=0, busy=0, state_out=000.
- Reset overrides everything, including mid-operation; there is no pending start after reset.
- Button edge detection: bt_rise = bt & ~bt_prev, with bt_prev registered per button.
- bt_prev resets to 1, so a button held through reset produces no edge until it is released and pressed again.
- Only one button action per cycle, by priority btc > btl > btr > btu > btd. Lower-priority edges in that cycle are discarded.
- States and encodings: MENU=000, GET_A=001, GET_B=010, EXEC=011, WAIT=100, SHOW=101, ERROR=110.
- MENU:
  - btr: op index +1, wrapping NUM_OPS-1 to 0.
  - btl: op index -1, wrapping 0 to NUM_OPS-1.
  - btu: op index jumps to 0.
  - btd: op index jumps to NUM_OPS-1.
  - btc: go to GET_A.
- GET_A:
  - btc: latch dataInBus into num1_out; go to GET_B if UNARY_MASK[op]=0, else EXEC.
  - btl: cancel to MENU; num1_out is unchanged.
  - Other buttons are ignored.
- GET_B:
  - btc: latch dataInBus into num2_out and go to EXEC.
  - btl: back to GET_A.
  - Other buttons are ignored.
  - num2_out is never written for unary ops.
- EXEC: lasts exactly one cycle; op_start = op_sel; clear the watchdog counter; go to WAIT.
- WAIT:
  - op_start=0.
  - The counter increments each cycle.
  - exec_done=1: go to SHOW if exec_err=0, else ERROR.
  - Timeout: if the counter reaches TIMEOUT with exec_done still 0 (TIMEOUT WAIT cycles elapsed), go to ERROR.
  - exec_done=1 in the same cycle the counter reaches TIMEOUT: exec_done wins.
  - Buttons are ignored in WAIT.
- SHOW: done=1; btc returns to MENU with done=0 on the next cycle. Operands and op index are retained.
- ERROR: err=1; btc returns to MENU with err=0. Operands are retained.
- exec_done and exec_err are ignored outside WAIT.
- Latency: a btc edge sampled at edge n in the final operand state gives EXEC (op_start high) during cycle n+1, and WAIT from n+2.
- Watchdog counter width is clog2(TIMEOUT+1).
- Operands are captured unsigned at full WIDTH with no truncation.

Test Plan:
1. Hold btc=1 through Reset=0 and release Reset -> state_out=000, op_sel=0000001, no transition until btc falls and rises again.
2. Binary add (op 0): btc; dataInBus=4, btc; dataInBus=3, btc -> num1_out=4, num2_out=3, op_start=0000001 for exactly 1 cycle, busy=1. Then exec_done=1 three cycles later -> done=1, state 101. Then btc -> MENU, done=0.
3. Menu wrap from op 0: btl -> op_sel=1000000; btr -> 0000001; btd -> 1000000; btu -> 0000001.
4. Unary sqrt: btr x6 -> op_sel=1000000; btc; dataInBus=16, btc -> GET_B skipped, op_start=1000000, num2_out unchanged from the previous value (3).
5. Error paths, bench TIMEOUT=8:
   - exec_done held 0 -> ERROR exactly 8 WAIT cycles after entry, err=1; btc -> MENU.
   - exec_done=1 with exec_err=1 -> ERROR, err=1.
6. Simultaneous btc+btr in MENU -> GET_A with op index unchanged. Reset=0 asserted mid-WAIT -> MENU on the next edge, busy=0, op_start=0, operands cleared to 0.

Source files
------------

// File: rtl/calc_menu_cu_p.sv
// Calculator control unit: button-driven operation menu, operand capture, one-hot dispatch
// and a watchdog-guarded start/done handshake with the arithmetic datapath.
module calc_menu_cu_p #(
   parameter int unsigned        WIDTH      = 8,
   parameter int unsigned        NUM_OPS    = 7,
   parameter logic [NUM_OPS-1:0] UNARY_MASK = 7'b1100000,
   parameter int unsigned        TIMEOUT    = 255
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [WIDTH-1:0]   dataInBus,
   input  logic               btl,
   input  logic               btr,
   input  logic               btu,
   input  logic               btd,
   input  logic               btc,
   input  logic               exec_done,
   input  logic               exec_err,
   output logic [NUM_OPS-1:0] op_sel,
   output logic [NUM_OPS-1:0] op_start,
   output logic [WIDTH-1:0]   num1_out,
   output logic [WIDTH-1:0]   num2_out,
   output logic               done,
   output logic               err,
   output logic               busy,
   output logic [2:0]         state_out
);
   localparam int unsigned IdxW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPS - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

   typedef enum logic [2:0] {
      StMenu  = 3'b000,
      StGetA  = 3'b001,
      StGetB  = 3'b010,
      StExec  = 3'b011,
      StWait  = 3'b100,
      StShow  = 3'b101,
      StError = 3'b110
   } state_e;

   state_e             state_q, state_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]   num1_q, num1_d, num2_q, num2_d;
   logic [4:0]         prev_q, prev_d, rise;
   logic [NUM_OPS-1:0] op_sel_q, op_sel_d, op_start_q, op_start_d;
   logic               done_q, done_d, err_q, err_d, busy_q, busy_d;

   // Bit order {c, l, r, u, d}; an if/else chain on rise gives c > l > r > u > d priority.
   assign prev_d = {btc, btl, btr, btu, btd};
   assign rise   = prev_d & ~prev_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      num1_d  = num1_q;
      num2_d  = num2_q;
      case (state_q)
         StMenu: begin
            if (rise[4]) begin
               state_d = StGetA;
            end else if (rise[3]) begin
               idx_d = (idx_q == '0) ? LastIdx : idx_q - IdxW'(1);
            end else if (rise[2]) begin
               idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
            end else if (rise[1]) begin
               idx_d = '0;
            end else if (rise[0]) begin
               idx_d = LastIdx;
            end
         end
         StGetA: begin
            if (rise[4]) begin
               num1_d  = dataInBus;
               state_d = UNARY_MASK[idx_q] ? StExec : StGetB;
            end else if (rise[3]) begin
               state_d = StMenu;
            end
         end
         StGetB: begin
            if (rise[4]) begin
               num2_d  = dataInBus;
               state_d = StExec;
            end else if (rise[3]) begin
               state_d = StGetA;
            end
         end
         StExec: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            // A completion in the same cycle the watchdog expires still counts as completion.
            if (exec_done) begin
               state_d = exec_err ? StError : StShow;
            end else if (cnt_d == CntMax) begin
               state_d = StError;
            end
         end
         StShow, StError: begin
            if (rise[4]) state_d = StMenu;
         end
         default: state_d = StMenu;
      endcase
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_OPS); i++) begin
         op_sel_d[i] = (idx_d == IdxW'(i));
      end
      op_start_d = (state_d == StExec) ? op_sel_d : '0;
      done_d     = (state_d == StShow);
      err_d      = (state_d == StError);
      busy_d     = (state_d == StExec) || (state_d == StWait);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q    <= StMenu;
         idx_q      <= '0;
         cnt_q      <= '0;
         num1_q     <= '0;
         num2_q     <= '0;
         prev_q     <= '1;
         op_sel_q   <= NUM_OPS'(1);
         op_start_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         num1_q     <= num1_d;
         num2_q     <= num2_d;
         prev_q     <= prev_d;
         op_sel_q   <= op_sel_d;
         op_start_q <= op_start_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign op_sel    = op_sel_q;
   assign op_start  = op_start_q;
   assign num1_out  = num1_q;
   assign num2_out  = num2_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_calc_menu_cu_p.sv
// Bench for calc_menu_cu_p: a directed vector table, a hand-written watchdog boundary sequence
// and a randomized phase checked against a behavioural model.
module tb_calc_menu_cu_p;
   localparam int         N   = 7;
   localparam int         TO  = 8;
   localparam logic [6:0] UM  = 7'b1100000;
   localparam bit [4:0]   B0  = 5'b00000;
   localparam bit [4:0]   BC  = 5'b10000;
   localparam bit [4:0]   BL  = 5'b01000;
   localparam bit [4:0]   BR  = 5'b00100;
   localparam bit [4:0]   BU  = 5'b00010;
   localparam bit [4:0]   BD  = 5'b00001;
   localparam int MENU = 0, GA = 1, GB = 2, EX = 3, WT = 4, SH = 5, ER = 6;

   logic       Clk, Reset, btl, btr, btu, btd, btc, exec_done, exec_err;
   logic [7:0] dataInBus, num1_out, num2_out;
   logic [6:0] op_sel, op_start;
   logic       done, err, busy;
   logic [2:0] state_out;

   calc_menu_cu_p #(
      .WIDTH      (8),
      .NUM_OPS    (7),
      .UNARY_MASK (7'b1100000),
      .TIMEOUT    (TO)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .dataInBus (dataInBus),
      .btl       (btl),
      .btr       (btr),
      .btu       (btu),
      .btd       (btd),
      .btc       (btc),
      .exec_done (exec_done),
      .exec_err  (exec_err),
      .op_sel    (op_sel),
      .op_start  (op_start),
      .num1_out  (num1_out),
      .num2_out  (num2_out),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .state_out (state_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: plain integers, modular index arithmetic, WAIT-cycle tally.
   int       m_st = MENU, m_idx = 0, m_waited = 0;
   bit [7:0] m_n1 = 0, m_n2 = 0;
   bit [4:0] m_prev = 5'h1f;

   task automatic model_step(input bit r, input bit [4:0] b, input bit [7:0] d,
                             input bit xd, input bit xe);
      bit [4:0] e;
      if (!r) begin
         m_st = MENU; m_idx = 0; m_n1 = 0; m_n2 = 0; m_prev = 5'h1f;
         return;
      end
      e = b & ~m_prev;
      m_prev = b;
      if (m_st == MENU) begin
         if (e[4]) m_st = GA;
         else if (e[3]) m_idx = (m_idx + N - 1) % N;
         else if (e[2]) m_idx = (m_idx + 1) % N;
         else if (e[1]) m_idx = 0;
         else if (e[0]) m_idx = N - 1;
      end else if (m_st == GA) begin
         if (e[4]) begin m_n1 = d; m_st = UM[m_idx] ? EX : GB; end
         else if (e[3]) m_st = MENU;
      end else if (m_st == GB) begin
         if (e[4]) begin m_n2 = d; m_st = EX; end
         else if (e[3]) m_st = GA;
      end else if (m_st == EX) begin
         m_st = WT; m_waited = 0;
      end else if (m_st == WT) begin
         m_waited++;
         if (xd) m_st = xe ? ER : SH;
         else if (m_waited >= TO) m_st = ER;
      end else if (e[4]) begin
         m_st = MENU;
      end
   endtask

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endfunction

   task automatic check_all(input int st, input int idx, input bit [7:0] n1, input bit [7:0] n2);
      logic [6:0] sel;
      sel = 7'(1) << idx;
      chk("state_out", 32'(state_out), 32'(st));
      chk("op_sel", 32'(op_sel), 32'(sel));
      chk("op_start", 32'(op_start), (st == EX) ? 32'(sel) : 32'd0);
      chk("num1_out", 32'(num1_out), 32'(n1));
      chk("num2_out", 32'(num2_out), 32'(n2));
      chk("done", 32'(done), 32'(st == SH));
      chk("err", 32'(err), 32'(st == ER));
      chk("busy", 32'(busy), 32'((st == EX) || (st == WT)));
   endtask

   task automatic tick(input bit r, input bit [4:0] b, input bit [7:0] d,
                       input bit xd, input bit xe);
      Reset = r;
      {btc, btl, btr, btu, btd} = b;
      dataInBus = d;
      exec_done = xd;
      exec_err  = xe;
      @(posedge Clk);
      model_step(r, b, d, xd, xe);
      #1;
   endtask

   typedef struct {
      bit       rst;
      bit [4:0] btn;
      bit [7:0] data;
      bit       xd, xe;
      int       st, idx;
      bit [7:0] n1, n2;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(bit r, bit [4:0] b, bit [7:0] d, bit xd, bit xe,
                               int st, int idx, bit [7:0] n1, bit [7:0] n2);
      vec_t v;
      v.rst = r; v.btn = b; v.data = d; v.xd = xd; v.xe = xe;
      v.st = st; v.idx = idx; v.n1 = n1; v.n2 = n2;
      tbl.push_back(v);
   endfunction

   initial begin
      bit got;
      Reset = 1'b0; {btc, btl, btr, btu, btd} = BC; dataInBus = 0; exec_done = 0; exec_err = 0;

      // btc held through reset: no edge until released and pressed again
      add(0, BC, 0, 0, 0, MENU, 0, 0, 0);  add(0, BC, 0, 0, 0, MENU, 0, 0, 0);
      add(1, BC, 0, 0, 0, MENU, 0, 0, 0);  add(1, BC, 0, 0, 0, MENU, 0, 0, 0);
      add(1, B0, 0, 0, 0, MENU, 0, 0, 0);
      // binary add
      add(1, BC, 0, 0, 0, GA, 0, 0, 0);    add(1, B0, 4, 0, 0, GA, 0, 0, 0);
      add(1, BC, 4, 0, 0, GB, 0, 4, 0);    add(1, B0, 3, 0, 0, GB, 0, 4, 0);
      add(1, BC, 3, 0, 0, EX, 0, 4, 3);
      for (int i = 0; i < 3; i++) add(1, B0, 3, 0, 0, WT, 0, 4, 3);
      add(1, B0, 3, 1, 0, SH, 0, 4, 3);    add(1, B0, 3, 0, 0, SH, 0, 4, 3);
      add(1, BC, 3, 0, 0, MENU, 0, 4, 3);  add(1, B0, 3, 0, 0, MENU, 0, 4, 3);
      // menu wrap and jumps
      add(1, BL, 0, 0, 0, MENU, 6, 4, 3);  add(1, B0, 0, 0, 0, MENU, 6, 4, 3);
      add(1, BR, 0, 0, 0, MENU, 0, 4, 3);  add(1, B0, 0, 0, 0, MENU, 0, 4, 3);
      add(1, BD, 0, 0, 0, MENU, 6, 4, 3);  add(1, B0, 0, 0, 0, MENU, 6, 4, 3);
      add(1, BU, 0, 0, 0, MENU, 0, 4, 3);  add(1, B0, 0, 0, 0, MENU, 0, 4, 3);
      // unary sqrt, then watchdog expiry
      for (int i = 1; i <= 6; i++) begin
         add(1, BR, 0, 0, 0, MENU, i, 4, 3); add(1, B0, 0, 0, 0, MENU, i, 4, 3);
      end
      add(1, BC, 16, 0, 0, GA, 6, 4, 3);   add(1, B0, 16, 1, 0, GA, 6, 4, 3);
      add(1, BC, 16, 0, 0, EX, 6, 16, 3);
      for (int i = 0; i < TO; i++) add(1, B0, 0, 0, 0, WT, 6, 16, 3);
      add(1, B0, 0, 0, 0, ER, 6, 16, 3);   add(1, B0, 0, 0, 0, ER, 6, 16, 3);
      add(1, BC, 0, 0, 0, MENU, 6, 16, 3); add(1, B0, 0, 0, 0, MENU, 6, 16, 3);
      // datapath error qualifier
      add(1, BC, 9, 0, 0, GA, 6, 16, 3);   add(1, B0, 9, 0, 0, GA, 6, 16, 3);
      add(1, BC, 9, 0, 0, EX, 6, 9, 3);    add(1, B0, 9, 0, 0, WT, 6, 9, 3);
      add(1, B0, 9, 0, 0, WT, 6, 9, 3);    add(1, B0, 9, 1, 1, ER, 6, 9, 3);
      add(1, B0, 9, 0, 0, ER, 6, 9, 3);    add(1, BC, 9, 0, 0, MENU, 6, 9, 3);
      add(1, B0, 9, 0, 0, MENU, 6, 9, 3);
      // back and cancel navigation
      add(1, BR, 0, 0, 0, MENU, 0, 9, 3);  add(1, B0, 0, 0, 0, MENU, 0, 9, 3);
      add(1, BC, 7, 0, 0, GA, 0, 9, 3);    add(1, B0, 7, 0, 0, GA, 0, 9, 3);
      add(1, BC, 7, 0, 0, GB, 0, 7, 3);    add(1, B0, 7, 0, 0, GB, 0, 7, 3);
      add(1, BL, 8, 0, 0, GA, 0, 7, 3);    add(1, B0, 8, 0, 0, GA, 0, 7, 3);
      add(1, BC, 8, 0, 0, GB, 0, 8, 3);    add(1, B0, 8, 0, 0, GB, 0, 8, 3);
      add(1, BR, 8, 0, 0, GB, 0, 8, 3);    add(1, B0, 8, 0, 0, GB, 0, 8, 3);
      add(1, BL, 8, 0, 0, GA, 0, 8, 3);    add(1, B0, 8, 0, 0, GA, 0, 8, 3);
      add(1, BL, 8, 0, 0, MENU, 0, 8, 3);  add(1, B0, 8, 0, 0, MENU, 0, 8, 3);
      // btc+btr together, then reset mid-WAIT
      add(1, BC | BR, 5, 0, 0, GA, 0, 8, 3); add(1, B0, 5, 0, 0, GA, 0, 8, 3);
      add(1, BC, 5, 0, 0, GB, 0, 5, 3);    add(1, B0, 6, 0, 0, GB, 0, 5, 3);
      add(1, BC, 6, 0, 0, EX, 0, 5, 6);    add(1, B0, 6, 0, 0, WT, 0, 5, 6);
      add(1, BC, 6, 0, 0, WT, 0, 5, 6);    add(0, B0, 6, 0, 0, MENU, 0, 0, 0);
      add(1, B0, 6, 0, 0, MENU, 0, 0, 0);

      foreach (tbl[i]) begin
         tick(tbl[i].rst, tbl[i].btn, tbl[i].data, tbl[i].xd, tbl[i].xe);
         check_all(tbl[i].st, tbl[i].idx, tbl[i].n1, tbl[i].n2);
      end

      // Full-width operands; completion arriving on the watchdog's last cycle wins.
      tick(1, BC, 8'hff, 0, 0); tick(1, B0, 8'hff, 0, 0);
      tick(1, BC, 8'hff, 0, 0); tick(1, B0, 8'h80, 0, 0);
      tick(1, BC, 8'h80, 0, 0);
      check_all(m_st, m_idx, m_n1, m_n2);
      chk("full_width_num1", 32'(num1_out), 32'hff);
      got = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
         tick(1, B0, 0, 0, 0);
         if (state_out == 3'(WT)) got = 1'b1;
      end
      chk("wait_entry_seen", 32'(got), 32'd1);
      for (int k = 0; k < TO - 1; k++) begin
         tick(1, B0, 0, 0, 0);
         chk("still_waiting", 32'(state_out), 32'(WT));
      end
      tick(1, B0, 0, 1, 0);
      chk("done_beats_timeout", 32'(state_out), 32'(SH));
      check_all(m_st, m_idx, m_n1, m_n2);
      tick(1, BC, 0, 0, 0);
      check_all(m_st, m_idx, m_n1, m_n2);

      for (int c = 0; c < 3000; c++) begin
         bit [4:0] b;
         for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 2) == 0);
         tick(($urandom_range(0, 299) != 0), b, 8'($urandom),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
         check_all(m_st, m_idx, m_n1, m_n2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
